// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and word/address types for the
// multi-port register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Address width for a register count; never narrower than one bit.
  function automatic int aw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  typedef logic [XLEN_DEF-1:0]           reg_t;
  typedef logic [aw_of(NREG_DEF)-1:0]    addr_t;

endpackage

// File: rtl/regfile_score.sv
// Per-register busy scoreboard. A write retires the pending producer of its
// destination; a reservation marks a new producer in flight. When both hit the
// same register in one cycle the reservation wins, because the reserving
// instruction is younger than the one that is writing back.
// Register 0 can never be busy. nbusy is the registered population count of
// the next-state busy vector, so it tracks busy with no extra lag.
module regfile_score
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NW   = 1,
  localparam int AW  = aw_of(NREG),
  localparam int CW  = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NW-1:0]        we,
  input  logic [NW-1:0][AW-1:0] wa,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_a,
  output logic [NREG-1:0]      busy,
  output logic [CW-1:0]        nbusy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;
  logic [CW-1:0]   count_next;
  logic            clr;
  logic            set;

  // Next-state busy bits: reservation beats retirement, entry 0 stays clear.
  always_comb begin
    busy_next = busy_q;
    clr       = 1'b0;
    set       = 1'b0;
    busy_next[0] = 1'b0;
    for (int a = 1; a < NREG; a++) begin
      clr = 1'b0;
      for (int i = 0; i < NW; i++) begin
        if (we[i] && (wa[i] == AW'(a))) begin
          clr = 1'b1;
        end
      end
      set = rsv_en && (rsv_a == AW'(a));
      if (set) begin
        busy_next[a] = 1'b1;
      end else if (clr) begin
        busy_next[a] = 1'b0;
      end
    end
  end

  // Population count of the next-state vector, registered alongside it.
  always_comb begin
    count_next = '0;
    for (int a = 0; a < NREG; a++) begin
      count_next = count_next + CW'(busy_next[a]);
    end
  end

  // Busy vector and count; async reset empties the scoreboard at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      nbusy  <= '0;
    end else begin
      busy_q <= busy_next;
      nbusy  <= count_next;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file for the RV32 decode/issue
// stage. Register 0 reads as zero and ignores writes. Reads are combinational;
// writes land on the rising edge, with the highest-numbered write port winning
// an address collision. With BYPASS set, a write in flight this cycle is
// forwarded to matching read ports (again highest port wins), and the busy bit
// seen on that port reflects the retirement unless the same register is being
// re-reserved in the same cycle. With SCORE clear the busy outputs are zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int BYPASS = 1,
  parameter int SCORE  = 1,
  localparam int AW    = aw_of(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NR-1:0][AW-1:0]   ra,
  output logic [NR-1:0][XLEN-1:0] rd,
  output logic [NR-1:0]           rbusy,
  input  logic [NW-1:0]           we,
  input  logic [NW-1:0][AW-1:0]   wa,
  input  logic [NW-1:0][XLEN-1:0] wd,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_a,
  output logic [AW:0]             nbusy
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  // Storage: later write ports are applied last so they override earlier ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (we[i] && (wa[i] != '0)) begin
          regs[wa[i]] <= wd[i];
        end
      end
    end
  end

  // Scoreboard is optional; without it nothing is ever reported busy.
  generate
    if (SCORE != 0) begin : g_score
      regfile_score #(
        .NREG (NREG),
        .NW   (NW)
      ) u_score (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wa     (wa),
        .rsv_en (rsv_en),
        .rsv_a  (rsv_a),
        .busy   (busy),
        .nbusy  (nbusy)
      );
    end else begin : g_noscore
      assign busy  = '0;
      assign nbusy = '0;
    end
  endgenerate

  // One read path per port: array lookup, then optional same-cycle forwarding.
  generate
    for (genvar j = 0; j < NR; j++) begin : g_read
      logic [XLEN-1:0] data;
      logic            bsy;
      logic            hit;

      // Read mux for this port; forwarding is suppressed while reset is held.
      always_comb begin
        data = '0;
        bsy  = 1'b0;
        hit  = 1'b0;
        if (ra[j] != '0) begin
          data = regs[ra[j]];
          bsy  = busy[ra[j]];
          if ((BYPASS != 0) && !reset) begin
            for (int i = 0; i < NW; i++) begin
              if (we[i] && (wa[i] == ra[j])) begin
                data = wd[i];
                hit  = 1'b1;
              end
            end
            if (hit) begin
              bsy = (SCORE != 0) && rsv_en && (rsv_a == ra[j]);
            end
          end
        end
      end

      assign rd[j]    = data;
      assign rbusy[j] = bsy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a vector table for the per-cycle behaviour
// plus hand sequences for the non-forwarding variant and mid-cycle reset.
module tb_regfile_mp;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][4:0]  ra;
  logic [1:0][31:0] rd;
  logic [1:0][31:0] rd_nb;
  logic [1:0]       rbusy;
  logic [1:0]       rbusy_nb;
  logic [1:0]       we;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic             rsv_en;
  logic [4:0]       rsv_a;
  logic [5:0]       nbusy;
  logic [5:0]       nbusy_nb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        rsv_en;
    logic [4:0]  rsv_a;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rbusy;
    logic [5:0]  e_nbusy;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(32), .NREG(32), .NR(2), .NW(2), .BYPASS(1), .SCORE(1)
  ) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_a(rsv_a), .nbusy(nbusy)
  );

  regfile_mp #(
    .XLEN(32), .NREG(32), .NR(2), .NW(2), .BYPASS(0), .SCORE(1)
  ) dut_nb (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_a(rsv_a), .nbusy(nbusy_nb)
  );

  function automatic vec_t mk(
    input logic [1:0] we_i, input logic [4:0] wa0_i, input logic [4:0] wa1_i,
    input logic [31:0] wd0_i, input logic [31:0] wd1_i,
    input logic rsv_en_i, input logic [4:0] rsv_a_i,
    input logic [4:0] ra0_i, input logic [4:0] ra1_i,
    input logic [31:0] e_rd0_i, input logic [31:0] e_rd1_i,
    input logic [1:0] e_rbusy_i, input logic [5:0] e_nbusy_i);
    vec_t v;
    v.we = we_i;       v.wa0 = wa0_i;     v.wa1 = wa1_i;
    v.wd0 = wd0_i;     v.wd1 = wd1_i;
    v.rsv_en = rsv_en_i; v.rsv_a = rsv_a_i;
    v.ra0 = ra0_i;     v.ra1 = ra1_i;
    v.e_rd0 = e_rd0_i; v.e_rd1 = e_rd1_i;
    v.e_rbusy = e_rbusy_i; v.e_nbusy = e_nbusy_i;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we     = v.we;
    wa[0]  = v.wa0;
    wa[1]  = v.wa1;
    wd[0]  = v.wd0;
    wd[1]  = v.wd1;
    rsv_en = v.rsv_en;
    rsv_a  = v.rsv_a;
    ra[0]  = v.ra0;
    ra[1]  = v.ra1;
  endtask

  task automatic setIdle(input logic [4:0] r0, input logic [4:0] r1);
    we = '0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_a = '0;
    ra[0] = r0; ra[1] = r1;
  endtask

  initial begin
    //              we    wa0 wa1 wd0           wd1  rsv  rsva ra0 ra1 rd0  rd1  rbusy  nbusy
    vecs[0]  = mk(2'b00, 0,  0,  0,            0,   0,   0,   5,  31, 0,   0,   2'b00, 0);
    vecs[1]  = mk(2'b01, 1,  0,  2,            0,   0,   0,   1,  0,  2,   0,   2'b00, 0);
    vecs[2]  = mk(2'b00, 0,  0,  0,            0,   0,   0,   1,  1,  2,   2,   2'b00, 0);
    vecs[3]  = mk(2'b01, 0,  0,  32'hFFFFFFFF, 0,   0,   0,   0,  1,  0,   2,   2'b00, 0);
    vecs[4]  = mk(2'b00, 0,  0,  0,            0,   0,   0,   0,  0,  0,   0,   2'b00, 0);
    vecs[5]  = mk(2'b11, 3,  3,  7,            9,   0,   0,   3,  1,  9,   2,   2'b00, 0);
    vecs[6]  = mk(2'b00, 0,  0,  0,            0,   0,   0,   3,  1,  9,   2,   2'b00, 0);
    vecs[7]  = mk(2'b00, 0,  0,  0,            0,   1,   4,   4,  3,  0,   9,   2'b00, 1);
    vecs[8]  = mk(2'b00, 0,  0,  0,            0,   0,   0,   4,  3,  0,   9,   2'b01, 1);
    vecs[9]  = mk(2'b01, 4,  0,  5,            0,   1,   4,   4,  4,  5,   5,   2'b11, 1);
    vecs[10] = mk(2'b01, 4,  0,  6,            0,   0,   0,   4,  1,  6,   2,   2'b00, 0);
    vecs[11] = mk(2'b00, 0,  0,  0,            0,   0,   0,   4,  3,  6,   9,   2'b00, 0);
    vecs[12] = mk(2'b11, 10, 11, 100,          111, 0,   0,   10, 11, 100, 111, 2'b00, 0);
    vecs[13] = mk(2'b00, 0,  0,  0,            0,   1,   10,  10, 11, 100, 111, 2'b00, 1);
    vecs[14] = mk(2'b00, 0,  0,  0,            0,   1,   11,  10, 11, 100, 111, 2'b01, 2);
    vecs[15] = mk(2'b00, 0,  0,  0,            0,   1,   11,  10, 11, 100, 111, 2'b11, 2);
    vecs[16] = mk(2'b00, 0,  0,  0,            0,   1,   0,   0,  11, 0,   111, 2'b10, 2);
    vecs[17] = mk(2'b10, 0,  12, 0,            5,   0,   0,   12, 10, 5,   100, 2'b10, 2);
    vecs[18] = mk(2'b11, 10, 11, 1,            2,   0,   0,   10, 11, 1,   2,   2'b00, 0);
    vecs[19] = mk(2'b00, 'x, 'x, 'x,           'x,  0,   'x,  10, 12, 1,   5,   2'b00, 0);

    // Reset from time zero, checked while still held.
    reset = 1'b1;
    setIdle(5'd5, 5'd31);
    #1;
    checkOutput("reset.nbusy", 64'(nbusy), 64'd0);
    checkOutput("reset.rd0", 64'(rd[0]), 64'd0);
    checkOutput("reset.rbusy", 64'(rbusy), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table-driven per-cycle vectors.
    for (int k = 0; k < NV; k++) begin
      applyStimulus(vecs[k]);
      #2;
      checkOutput($sformatf("v%0d.rd0", k), 64'(rd[0]), 64'(vecs[k].e_rd0));
      checkOutput($sformatf("v%0d.rd1", k), 64'(rd[1]), 64'(vecs[k].e_rd1));
      checkOutput($sformatf("v%0d.rbusy", k), 64'(rbusy), 64'(vecs[k].e_rbusy));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.nbusy", k), 64'(nbusy), 64'(vecs[k].e_nbusy));
    end

    // Without forwarding the new value appears only after the edge.
    setIdle(5'd20, 5'd0);
    we = 2'b01; wa[0] = 5'd20; wd[0] = 32'd55;
    #2;
    checkOutput("nb.pre.rd0", 64'(rd_nb[0]), 64'd0);
    checkOutput("byp.pre.rd0", 64'(rd[0]), 64'd55);
    @(posedge clk);
    #1;
    setIdle(5'd20, 5'd0);
    #2;
    checkOutput("nb.post.rd0", 64'(rd_nb[0]), 64'd55);
    checkOutput("byp.post.rd0", 64'(rd[0]), 64'd55);
    @(posedge clk);
    #1;

    // Reserve 6 and 7, then fill 6 while re-reserving it so both stay busy.
    setIdle(5'd6, 5'd7);
    rsv_en = 1'b1; rsv_a = 5'd6;
    @(posedge clk);
    #1;
    rsv_a = 5'd7;
    @(posedge clk);
    #1;
    we = 2'b01; wa[0] = 5'd6; wd[0] = 32'hAA; rsv_a = 5'd6;
    @(posedge clk);
    #1;
    checkOutput("fill.nbusy", 64'(nbusy), 64'd2);
    setIdle(5'd6, 5'd7);
    #2;
    checkOutput("fill.rd0", 64'(rd[0]), 64'hAA);
    checkOutput("fill.rbusy", 64'(rbusy), 64'b11);
    @(posedge clk);
    #1;

    // Active inputs, then reset mid-cycle: everything clears before the edge.
    we = 2'b01; wa[0] = 5'd6; wd[0] = 32'h1234; rsv_en = 1'b1; rsv_a = 5'd7;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst.rd0", 64'(rd[0]), 64'd0);
    checkOutput("midrst.rd1", 64'(rd[1]), 64'd0);
    checkOutput("midrst.rbusy", 64'(rbusy), 64'd0);
    checkOutput("midrst.nbusy", 64'(nbusy), 64'd0);
    checkOutput("midrst.nb.nbusy", 64'(nbusy_nb), 64'd0);
    @(posedge clk);
    #1;
    setIdle(5'd6, 5'd7);
    reset = 1'b0;
    #2;
    checkOutput("postrst.rd0", 64'(rd[0]), 64'd0);
    checkOutput("postrst.rd1", 64'(rd[1]), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("postrst.nbusy", 64'(nbusy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
